data_mem_unit: RTL and testbench
================================

Name: data_mem_unit

Overview:
- Data memory that sits directly downstream of the pipeline MEM stage.
- Consumes mem_addr, mem_write_data, mem_wr and the sb/sh/lb/lh qualifiers; produces mem_read_data, which the pipeline captures into MEM/WB on the same edge.
- Big-endian, byte-addressed, word-organised storage with sub-word lane steering.
- Power-up/reset clear sequencer reports busy until every word has been zeroed.

Parameters:
- ADDR_BITS, 10, log2 of word count. Storage = 2^ADDR_BITS 32-bit words; word index = mem_addr[ADDR_BITS+1:2].

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- mem_addr  input  32  byte address
- mem_write_data  input  32  store data, unfiltered register value; sub-word data taken from low bits
- mem_wr  input  1  store strobe
- mem_sb  input  1  store byte qualifier
- mem_sh  input  1  store halfword qualifier
- mem_lb  input  1  load byte qualifier
- mem_lh  input  1  load halfword qualifier
- mem_read_data  output  32  load data, right-justified, upper bits zero
- busy  output  1  clear sweep in progress
- misalign  output  1  sticky misaligned-access flag (see Optional Feature)
- err_addr  output  32  address of first misaligned access (see Optional Feature)

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high. Port names are clk and reset.

Addressing:
- mem_addr bits above ADDR_BITS+1 are ignored; addresses alias.
- Byte offset o = mem_addr[1:0]. Offset 0 maps to bits [31:24], offset 3 to bits [7:0].

Clear FSM (states CLEAR, IDLE):
- Any edge with reset=1: state<=CLEAR, ptr<=0, misalign<=0, err_addr<=0.
- CLEAR with reset=0: word[ptr]<=0, ptr<=ptr+1. At ptr==2^ADDR_BITS-1, write it and go to IDLE.
- busy=1 when reset=1 or state==CLEAR. After reset falls, busy drops exactly 2^ADDR_BITS edges later.
- Reset asserted mid-sweep restarts the sweep at ptr 0.
- While busy: mem_read_data=0 and stores are dropped.

Stores (IDLE only, mem_wr=1, written on the rising edge):
- Qualifier priority: sb over sh over word.
- sb: mem_write_data[7:0] written to lane o; other lanes unchanged.
- sh: mem_write_data[15:0] written to bytes o and o+1, with o[0] assumed 0 (see Optional Feature).
- word: all 32 bits written.

Loads (combinational, asynchronous read of the array):
- lb has priority over lh; neither set returns the full word.
- lb: selected byte placed in [7:0], bits [31:8]=0.
- lh: halfword (o[1] selects upper or lower) placed in [15:0], bits [31:16]=0.
- Sign extension is performed downstream in write-back, never here.
- A read of the same word being written in that cycle returns the old contents; the new data is visible the next cycle.
- mem_read_data is driven regardless of mem_wr.

Reset values:
- mem_read_data=0, busy=1, misalign=0, err_addr=0.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.

With the macro defined:
- Misaligned conditions, evaluated in IDLE only:
  - word access with o!=0;
  - halfword access (sh, or lh without lb) with o[0]=1.
- A misaligned store is suppressed.
- A misaligned load returns 0.
- On the first misaligned access after reset: misalign<=1 and err_addr<=mem_addr. Later misaligned accesses do not overwrite err_addr.
- A "load" for this check is any cycle with mem_wr=0 and lb or lh set; a plain word read with mem_wr=0 is checked only when lb=lh=0 and the address is misaligned.

Without the macro:
- The low offset bits are masked: o forced to 0 for word accesses and o[0] forced to 0 for halfword accesses.
- No access is suppressed.
- misalign and err_addr are tied to 0.

Test Plan (ADDR_BITS=4):
- Clear sweep: preload word 3 = 0xDEADBEEF, pulse reset 2 cycles -> busy=1 for 2 cycles plus exactly 16 edges after release; then word 3 reads 0x00000000. A store issued while busy has no effect.
- Byte store/load: word store 0x11223344 to addr 0x8, then sb 0x000000AA to addr 0x9 -> word read 0x11AA3344. lb at addr 0x9 -> 0x000000AA; lb at addr 0xB -> 0x00000044.
- Halfword: sh 0x0000BEEF to addr 0xA over 0x11AA3344 -> word 0x11AABEEF. lh at addr 0x8 -> 0x000011AA. Both lb and lh set at addr 0x8 -> 0x00000011.
- Aliasing and read-during-write: store 0xCAFEF00D at addr 0x40 -> word read at addr 0x0 returns 0xCAFEF00D. In the same-cycle write, the read returns the old value; the next cycle returns the new value.
- Reset mid-sweep: assert reset at ptr=7 -> ptr restarts at 0; busy held another 16 edges after release.
- Misalignment:
  - With DMEM_MISALIGN_TRAP_EN: word store to 0x5 is suppressed, misalign=1, err_addr=0x5; a later lh at 0x7 leaves err_addr=0x5.
  - Without the macro: the same store writes word index 1.

Source files
------------

// File: rtl/data_mem_unit.sv
// data_mem_unit: big-endian byte-addressed data memory with sub-word lanes and a reset clear sweep.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module data_mem_unit #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  input  logic        mem_wr,
  input  logic        mem_sb,
  input  logic        mem_sh,
  input  logic        mem_lb,
  input  logic        mem_lh,
  output logic [31:0] mem_read_data,
  output logic        busy,
  output logic        misalign,
  output logic [31:0] err_addr
);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t               r_state;
  logic [ADDR_BITS-1:0] r_ptr;
  logic [31:0]          r_mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] w_idx, w_waddr;
  logic [1:0]           w_o;
  logic                 w_clr, w_st, w_st_mis, w_ld_mis, w_unused;
  logic [3:0]           w_be, w_we;
  logic [31:0]          w_wdat, w_rword;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  assign w_unused = &{1'b0, mem_addr[31:ADDR_BITS+2]};
  assign w_idx    = mem_addr[ADDR_BITS+1:2];
  assign w_o      = mem_addr[1:0];
  assign busy     = reset | (r_state == CLEAR);
  assign w_clr    = ~reset & (r_state == CLEAR);
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        r_misalign;
  logic [31:0] r_err_addr;
  assign w_st_mis = ~mem_sb & (mem_sh ? w_o[0] : |w_o);
  assign w_ld_mis = ~mem_lb & (mem_lh ? w_o[0] : |w_o);
  assign misalign = r_misalign;
  assign err_addr = r_err_addr;
  always_ff @(posedge clk)
    if (reset) begin
      r_misalign <= 1'b0;
      r_err_addr <= '0;
    end else if (~busy & (mem_wr ? w_st_mis : w_ld_mis) & ~r_misalign) begin
      r_misalign <= 1'b1;
      r_err_addr <= mem_addr;
    end
`else
  assign w_st_mis = 1'b0;
  assign w_ld_mis = 1'b0;
  assign misalign = 1'b0;
  assign err_addr = '0;
`endif
  assign w_st = ~busy & mem_wr & ~w_st_mis;
  // Lane i of the byte enable covers bits [8i+7:8i]; offset 0 is the top lane.
  always_comb begin
    w_be    = mem_sb ? 4'b1000 >> w_o : mem_sh ? (w_o[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    w_we    = w_clr ? 4'b1111 : w_st ? w_be : 4'b0000;
    w_waddr = w_clr ? r_ptr : w_idx;
    w_wdat  = w_clr ? 32'h0 : mem_sb ? {4{mem_write_data[7:0]}} :
              mem_sh ? {2{mem_write_data[15:0]}} : mem_write_data;
  end
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (w_we[i]) r_mem[w_waddr][8*i +: 8] <= w_wdat[8*i +: 8];
  always_comb begin
    w_rword       = r_mem[w_idx];
    w_byte        = w_rword[{~w_o, 3'b000} +: 8];
    w_half        = w_o[1] ? w_rword[15:0] : w_rword[31:16];
    mem_read_data = (busy | w_ld_mis) ? 32'h0 : mem_lb ? {24'h0, w_byte} :
                    mem_lh ? {16'h0, w_half} : w_rword;
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
    end else if (r_state == CLEAR) begin
      r_ptr <= r_ptr + 1'b1;
      if (&r_ptr) r_state <= IDLE;
    end
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: directed plus random checks of data_mem_unit against a byte-lane reference model.
module tb_data_mem_unit;
  localparam int AB = 4;
  localparam int N  = 2**AB;
  logic        clk = 1'b0;
  logic        reset, mem_wr, mem_sb, mem_sh, mem_lb, mem_lh, busy, misalign;
  logic [31:0] mem_addr, mem_write_data, mem_read_data, err_addr;
  int          total = 0, bad = 0, cnt = N;
  logic [31:0] m [N];
  bit          mis = 0;
  logic [31:0] err = '0, got;
  always #5 clk = ~clk;
  data_mem_unit #(.ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_wr(mem_wr), .mem_sb(mem_sb), .mem_sh(mem_sh), .mem_lb(mem_lb), .mem_lh(mem_lh),
    .mem_read_data(mem_read_data), .busy(busy), .misalign(misalign), .err_addr(err_addr)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  function automatic bit st_bad(input logic [31:0] a, input logic sb, input logic sh);
`ifdef DMEM_MISALIGN_TRAP_EN
    return !sb && (sh ? a[0] : a[1:0] != 0);
`else
    return 0;
`endif
  endfunction
  function automatic bit ld_bad(input logic [31:0] a, input logic lb, input logic lh);
`ifdef DMEM_MISALIGN_TRAP_EN
    return !lb && (lh ? a[0] : a[1:0] != 0);
`else
    return 0;
`endif
  endfunction
  function automatic logic [31:0] ref_rd(input logic r, input logic [31:0] a, input logic lb, input logic lh);
    logic [31:0] w = m[a[AB+1:2]];
    int o = int'(a[1:0]);
    if (r || cnt > 0 || ld_bad(a, lb, lh)) return 0;
    if (lb) return (w >> (8 * (3 - o))) & 32'hff;
    if (lh) return (w >> (o >= 2 ? 0 : 16)) & 32'hffff;
    return w;
  endfunction
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic sb, input logic sh, input logic lb, input logic lh, input string tag);
    int i, o, s;
    reset = r; mem_addr = a; mem_write_data = d; mem_wr = w;
    mem_sb = sb; mem_sh = sh; mem_lb = lb; mem_lh = lh;
    #1;
    got = mem_read_data;
    check({tag, ".rd"}, mem_read_data, ref_rd(r, a, lb, lh));
    check({tag, ".busy"}, busy, r || cnt > 0);
    check({tag, ".mis"}, misalign, mis);
    check({tag, ".err"}, err_addr, err);
    @(posedge clk);
    i = int'(a[AB+1:2]);
    o = int'(a[1:0]);
    if (r) begin
      cnt = N; mis = 0; err = '0;
      foreach (m[k]) m[k] = '0;
    end else if (cnt > 0) cnt--;
    else begin
      if (w && !st_bad(a, sb, sh)) begin
        if (sb) begin
          s = 8 * (3 - o);
          m[i] = (m[i] & ~(32'hff << s)) | ((d & 32'hff) << s);
        end else if (sh) begin
          s = o >= 2 ? 0 : 16;
          m[i] = (m[i] & ~(32'hffff << s)) | ((d & 32'hffff) << s);
        end else m[i] = d;
      end
      if ((w ? st_bad(a, sb, sh) : ld_bad(a, lb, lh)) && !mis) begin
        mis = 1; err = a;
      end
    end
    @(negedge clk);
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic sb, input logic sh, input string tag);
    step(0, a, d, 1, sb, sh, 0, 0, tag);
  endtask
  task automatic ld(input logic [31:0] a, input logic lb, input logic lh, input string tag);
    step(0, a, 0, 0, 0, 0, lb, lh, tag);
  endtask
  initial begin
    foreach (m[k]) m[k] = '0;
    reset = 1; mem_addr = 0; mem_write_data = 0;
    mem_wr = 0; mem_sb = 0; mem_sh = 0; mem_lb = 0; mem_lh = 0;
    @(posedge clk);
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, "rst");
    for (int n = 0; n < N; n++)
      if (n == 3) st(32'hC, 32'h12345678, 0, 0, "busy_st");
      else ld(32'hC, 0, 0, "sweep");
    ld(32'hC, 0, 0, "post_sweep");
    check("busy_store_dropped", got, 32'h0);
    st(32'hC, 32'hDEADBEEF, 0, 0, "preload");
    ld(32'hC, 0, 0, "preload_rd");
    check("preload_val", got, 32'hDEADBEEF);
    step(1, 32'hC, 0, 0, 0, 0, 0, 0, "rst2a");
    step(1, 32'hC, 0, 0, 0, 0, 0, 0, "rst2b");
    repeat (N) ld(32'hC, 0, 0, "sweep2");
    ld(32'hC, 0, 0, "cleared");
    check("cleared_val", got, 32'h0);
    st(32'h8, 32'h11223344, 0, 0, "w8");
    st(32'h9, 32'h000000AA, 1, 0, "sb9");
    ld(32'h8, 0, 0, "rd8");
    check("sb_word", got, 32'h11AA3344);
    ld(32'h9, 1, 0, "lb9");
    check("lb9_val", got, 32'h000000AA);
    ld(32'hB, 1, 0, "lbB");
    check("lbB_val", got, 32'h00000044);
    st(32'hA, 32'h0000BEEF, 0, 1, "shA");
    ld(32'h8, 0, 0, "rd8h");
    check("sh_word", got, 32'h11AABEEF);
    ld(32'h8, 0, 1, "lh8");
    check("lh8_val", got, 32'h000011AA);
    ld(32'h8, 1, 1, "lblh8");
    check("lblh8_val", got, 32'h00000011);
    st(32'h40, 32'hCAFEF00D, 0, 0, "alias_st");
    check("rdw_old", got, 32'h0);
    ld(32'h0, 0, 0, "alias_rd");
    check("alias_val", got, 32'hCAFEF00D);
    step(1, 0, 0, 0, 0, 0, 0, 0, "mid_rst");
    repeat (7) ld(32'h0, 0, 0, "mid_sweep");
    step(1, 0, 0, 0, 0, 0, 0, 0, "mid_rst2");
    repeat (N) ld(32'h0, 0, 0, "mid_sweep2");
    ld(32'h0, 0, 0, "mid_done");
    check("mid_busy_low", busy, 1'b0);
    st(32'h5, 32'h12345678, 0, 0, "mis_st");
    ld(32'h4, 0, 0, "mis_rd");
`ifdef DMEM_MISALIGN_TRAP_EN
    check("mis_suppressed", got, 32'h0);
    check("mis_flag", misalign, 1'b1);
    check("mis_err", err_addr, 32'h5);
    ld(32'h7, 0, 1, "mis_lh");
    check("mis_err_kept", err_addr, 32'h5);
`else
    check("mis_masked", got, 32'h12345678);
    check("mis_flag", misalign, 1'b0);
`endif
    repeat (400)
      step($urandom_range(0, 60) == 0, $urandom_range(0, 127), $urandom, 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rand");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
